// File: rtl/lane_packet_receiver_pkg.sv
// Shared frame types and default link parameters for the GPIO link receiver.
// Pure declarations: no latency, no flow control.
package lane_packet_receiver_pkg;

  typedef enum logic [1:0] {
    PKT_DATA  = 2'b00,
    PKT_ACK   = 2'b01,
    PKT_READY = 2'b10,
    PKT_LOST  = 2'b11
  } pkt_type_t;

  localparam int         PAYLOAD_BEATS  = 16;
  localparam logic [7:0] SYNC_PATTERN   = 8'h7E;
  localparam int         TIMEOUT_CYCLES = 5000;
  localparam int         CNT_W          = 4;

endpackage

// File: rtl/lane_packet_receiver_gpio_synchronizer.sv
// 2-FF synchronizer with rising-edge detect for a group of asynchronous pins.
// Latency: 2 clk to q, rise valid the same cycle as q; no backpressure.
module gpio_synchronizer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/lane_packet_receiver.sv
// Link-layer receiver: sync hunt, header/payload deserialization, lane parity, dup filtering.
// Pulses appear 1 clk after the final-bit sclk edge (plus 2-FF sync); no backpressure, sender-paced.
module lane_packet_receiver #(
  parameter int         PAYLOAD_BEATS  = lane_packet_receiver_pkg::PAYLOAD_BEATS,
  parameter logic [7:0] SYNC_PATTERN   = lane_packet_receiver_pkg::SYNC_PATTERN,
  parameter int         TIMEOUT_CYCLES = lane_packet_receiver_pkg::TIMEOUT_CYCLES,
  parameter int         CNT_W          = lane_packet_receiver_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk_in,
  input  logic                       serial_in_h,
  input  logic [3:0]                 serial_in_d,
  output logic [4*PAYLOAD_BEATS-1:0] payload,
  output logic                       payload_valid,
  output logic                       payload_seq,
  output logic                       ack_received,
  output logic                       ack_seqNum,
  output logic                       ready_received,
  output logic                       lost_received,
  output logic                       send_ack,
  output logic                       send_ack_seq,
  output logic [CNT_W-1:0]           packets_received_cnt,
  output logic [CNT_W-1:0]           errors_cnt,
  output logic                       busy
);

  import lane_packet_receiver_pkg::*;

  localparam int PW = 4 * PAYLOAD_BEATS;
  localparam int BW = $clog2(PAYLOAD_BEATS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_HUNT, S_HDR, S_PAYLOAD, S_PARITY, S_EMIT
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      window, window_nxt;
  logic [1:0]      hdr_sr;
  logic [1:0]      hdr_cnt;
  logic            seq_r;
  logic [BW-1:0]   beat_cnt;
  logic [PW-1:0]   shadow;
  logic [3:0]      par_acc;
  logic [TW-1:0]   timer;
  logic            last_seq;

  logic [5:0]      sync_q;
  logic [5:0]      sync_rise;
  logic            sync_unused;
  logic            sclk_rise;
  logic            h_bit;
  logic [3:0]      d_bits;

  logic            active, timer_exp, abort, parity_ok;
  logic            ctl_done, data_done, parity_fail;
  pkt_type_t       hdr_type;

  // One synchronizer for clock and lanes so their sampling latency is identical.
  gpio_synchronizer #(.W(6)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({serial_in_d, serial_in_h, sclk_in}),
    .q    (sync_q),
    .rise (sync_rise)
  );

  assign sclk_rise   = sync_rise[0];
  assign h_bit       = sync_q[1];
  assign d_bits      = sync_q[5:2];
  assign sync_unused = ^{sync_rise[5:1], sync_q[0]};
  assign busy        = (state != S_HUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    window_nxt  = {window[6:0], h_bit};
    hdr_type    = pkt_type_t'(hdr_sr);
    active      = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_PARITY);
    timer_exp   = (timer == TW'(TIMEOUT_CYCLES - 1));
    abort       = active && !sclk_rise && timer_exp;
    parity_ok   = ((par_acc ^ d_bits) == 4'h0);
    ctl_done    = 1'b0;
    data_done   = 1'b0;
    parity_fail = 1'b0;
    case (state)
      S_HUNT: begin
        if (sclk_rise && window_nxt == SYNC_PATTERN) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (sclk_rise) begin
          if (hdr_cnt == 2'd2) begin
            ctl_done  = (hdr_type != PKT_DATA);
            state_nxt = (hdr_type == PKT_DATA) ? S_PAYLOAD : S_EMIT;
          end
        end else if (abort) begin
          state_nxt = S_HUNT;
        end
      end
      S_PAYLOAD: begin
        if (sclk_rise) begin
          if (beat_cnt == BW'(PAYLOAD_BEATS - 1)) state_nxt = S_PARITY;
        end else if (abort) begin
          state_nxt = S_HUNT;
        end
      end
      S_PARITY: begin
        if (sclk_rise) begin
          data_done   = parity_ok;
          parity_fail = !parity_ok;
          state_nxt   = parity_ok ? S_EMIT : S_HUNT;
        end else if (abort) begin
          state_nxt = S_HUNT;
        end
      end
      S_EMIT:  state_nxt = S_HUNT;
      default: state_nxt = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window               <= '0;
      hdr_sr               <= '0;
      hdr_cnt              <= '0;
      seq_r                <= 1'b0;
      beat_cnt             <= '0;
      shadow               <= '0;
      par_acc              <= '0;
      timer                <= '0;
      last_seq             <= 1'b1;
      payload              <= '0;
      payload_valid        <= 1'b0;
      payload_seq          <= 1'b0;
      ack_received         <= 1'b0;
      ack_seqNum           <= 1'b0;
      ready_received       <= 1'b0;
      lost_received        <= 1'b0;
      send_ack             <= 1'b0;
      send_ack_seq         <= 1'b0;
      packets_received_cnt <= '0;
      errors_cnt           <= '0;
    end else begin
      payload_valid  <= 1'b0;
      ack_received   <= 1'b0;
      ready_received <= 1'b0;
      lost_received  <= 1'b0;
      send_ack       <= 1'b0;

      // The window only lives in HUNT; leaving it always starts the next hunt clean.
      if (state != S_HUNT)  window <= '0;
      else if (sclk_rise)   window <= window_nxt;

      if (!active || sclk_rise) timer <= '0;
      else                      timer <= timer + TW'(1);

      if (state != S_HDR) begin
        hdr_cnt <= '0;
      end else if (sclk_rise) begin
        hdr_cnt <= hdr_cnt + 2'd1;
        if (hdr_cnt == 2'd2) seq_r  <= h_bit;
        else                 hdr_sr <= {hdr_sr[0], h_bit};
      end

      if (state != S_PAYLOAD) begin
        beat_cnt <= '0;
      end else if (sclk_rise) begin
        beat_cnt <= beat_cnt + BW'(1);
        shadow   <= {d_bits, shadow[PW-1:4]};
        par_acc  <= par_acc ^ d_bits;
      end
      if (state == S_HUNT || state == S_HDR) par_acc <= '0;

      if (ctl_done) begin
        case (hdr_type)
          PKT_ACK: begin
            ack_received <= 1'b1;
            ack_seqNum   <= h_bit;
          end
          PKT_READY: ready_received <= 1'b1;
          PKT_LOST:  lost_received  <= 1'b1;
          default:   ;
        endcase
      end

      // Duplicates are still counted and re-ACKed in case our earlier ACK was lost.
      if (data_done) begin
        packets_received_cnt <= packets_received_cnt + CNT_W'(1);
        send_ack             <= 1'b1;
        send_ack_seq         <= seq_r;
        if (seq_r != last_seq) begin
          payload       <= shadow;
          payload_valid <= 1'b1;
          payload_seq   <= seq_r;
          last_seq      <= seq_r;
        end
      end

      if (parity_fail || abort) errors_cnt <= errors_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lane_packet_receiver.sv
// Directed-frame bench: stimulus pushes expected output events, a negedge monitor pops and compares.
module tb_lane_packet_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk_in = 1'b0;
  logic        serial_in_h = 1'b0;
  logic [3:0]  serial_in_d = 4'h0;
  logic [63:0] payload;
  logic        payload_valid, payload_seq, ack_received, ack_seqNum;
  logic        ready_received, lost_received, send_ack, send_ack_seq, busy;
  logic [3:0]  packets_received_cnt, errors_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  pulses;   // {payload_valid, send_ack, ack, ready, lost}
    logic [63:0] pl;
    logic        pseq;
    logic        ackseq;
    logic        sackseq;
    logic [3:0]  pcnt;
    logic [3:0]  ecnt;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs;
  ev_t expv;

  localparam logic [63:0] PL_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PL_B = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] PL_C = 64'h7E7E_7E7E_7E7E_7E7E;
  localparam logic [63:0] PL_D = 64'hA5A5_5A5A_0F0F_F0F0;

  lane_packet_receiver dut (
    .clk                  (clk),
    .rst                  (rst),
    .sclk_in              (sclk_in),
    .serial_in_h          (serial_in_h),
    .serial_in_d          (serial_in_d),
    .payload              (payload),
    .payload_valid        (payload_valid),
    .payload_seq          (payload_seq),
    .ack_received         (ack_received),
    .ack_seqNum           (ack_seqNum),
    .ready_received       (ready_received),
    .lost_received        (lost_received),
    .send_ack             (send_ack),
    .send_ack_seq         (send_ack_seq),
    .packets_received_cnt (packets_received_cnt),
    .errors_cnt           (errors_cnt),
    .busy                 (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && ({payload_valid, send_ack, ack_received, ready_received, lost_received} != 5'b0)) begin
      obs = '{pulses: {payload_valid, send_ack, ack_received, ready_received, lost_received},
              pl: payload, pseq: payload_seq, ackseq: ack_seqNum,
              sackseq: send_ack & send_ack_seq, pcnt: packets_received_cnt, ecnt: errors_cnt};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got %h required none", obs);
      end else begin
        expv = exp_q.pop_front();
        if (obs !== expv) begin
          n_err++;
          $display("FAIL event: got %h required %h", obs, expv);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_ev(input logic [4:0] p, input logic [63:0] pl, input logic ps,
                         input logic as, input logic ss, input logic [3:0] pc, input logic [3:0] ec);
    exp_q.push_back('{pulses: p, pl: pl, pseq: ps, ackseq: as, sackseq: ss, pcnt: pc, ecnt: ec});
  endtask

  task automatic send_bit(input logic h, input logic [3:0] d);
    @(negedge clk);
    serial_in_h = h;
    serial_in_d = d;
    repeat (4) @(negedge clk);
    sclk_in = 1'b1;
    repeat (4) @(negedge clk);
    sclk_in = 1'b0;
  endtask

  // beats < 16 truncates the frame before the parity beat; noise drives 0x7E on the header lane during payload.
  task automatic send_frame(input logic [1:0] typ, input logic seq, input logic [63:0] pl,
                            input logic [3:0] par_flip, input int beats, input logic noise);
    logic [7:0] sync  = 8'h7E;
    logic [7:0] npat  = 8'h7E;
    logic [3:0] par   = 4'h0;
    logic [3:0] beat;
    for (int i = 7; i >= 0; i--) send_bit(sync[i], 4'h0);
    send_bit(typ[1], 4'h0);
    send_bit(typ[0], 4'h0);
    send_bit(seq, 4'h0);
    if (typ == 2'b00) begin
      for (int k = 0; k < beats; k++) begin
        beat = pl[4*k +: 4];
        par  = par ^ beat;
        send_bit(noise ? npat[7 - (k % 8)] : 1'b0, beat);
      end
      if (beats == 16) send_bit(1'b0, par ^ par_flip);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {46'b0, payload, payload_valid, payload_seq, ack_received, ack_seqNum,
                 ready_received, lost_received, send_ack, send_ack_seq,
                 packets_received_cnt, errors_cnt, busy}, 128'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");

    push_ev(5'b11000, PL_A, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0);
    send_frame(2'b00, 1'b0, PL_A, 4'h0, 16, 1'b0);

    push_ev(5'b01000, PL_A, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0);
    send_frame(2'b00, 1'b0, PL_A, 4'h0, 16, 1'b0);

    push_ev(5'b00100, PL_A, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0);
    send_frame(2'b01, 1'b1, 64'h0, 4'h0, 16, 1'b0);
    push_ev(5'b00010, PL_A, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0);
    send_frame(2'b10, 1'b0, 64'h0, 4'h0, 16, 1'b0);
    push_ev(5'b00001, PL_A, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0);
    send_frame(2'b11, 1'b0, 64'h0, 4'h0, 16, 1'b0);

    send_frame(2'b00, 1'b1, PL_B, 4'b0100, 16, 1'b0);
    check("parity_err_busy", {127'b0, busy}, 128'd0);
    check("parity_err_cnt", {124'b0, errors_cnt}, 128'd1);
    check("parity_err_pcnt", {124'b0, packets_received_cnt}, 128'd2);
    check("parity_err_payload", {64'b0, payload}, {64'b0, PL_A});

    send_frame(2'b00, 1'b1, PL_B, 4'h0, 5, 1'b0);
    repeat (4900) @(negedge clk);
    check("timeout_not_yet_busy", {127'b0, busy}, 128'd1);
    check("timeout_not_yet_err", {124'b0, errors_cnt}, 128'd1);
    repeat (200) @(negedge clk);
    check("timeout_busy", {127'b0, busy}, 128'd0);
    check("timeout_err", {124'b0, errors_cnt}, 128'd2);

    push_ev(5'b11000, PL_B, 1'b1, 1'b1, 1'b1, 4'd3, 4'd2);
    send_frame(2'b00, 1'b1, PL_B, 4'h0, 16, 1'b0);

    push_ev(5'b11000, PL_C, 1'b0, 1'b1, 1'b0, 4'd4, 4'd2);
    send_frame(2'b00, 1'b0, PL_C, 4'h0, 16, 1'b1);
    check("noise_frame_idle", {127'b0, busy}, 128'd0);

    send_bit(1'b1, 4'h3); send_bit(1'b0, 4'h0); send_bit(1'b1, 4'hF);
    send_bit(1'b1, 4'h0); send_bit(1'b0, 4'h5); send_bit(1'b0, 4'h0);
    send_bit(1'b1, 4'hA);
    check("garbage_no_sync", {127'b0, busy}, 128'd0);
    send_frame(2'b00, 1'b1, PL_C, 4'h0, 6, 1'b1);
    check("mid_payload_busy", {127'b0, busy}, 128'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("mid_frame_reset");

    push_ev(5'b11000, PL_D, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0);
    send_frame(2'b00, 1'b0, PL_D, 4'h0, 16, 1'b0);

    repeat (20) @(negedge clk);
    check("events_outstanding", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(20 * 60000);
    n_err++;
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lane_packet_receiver.md
Name: lane_packet_receiver

Overview:
Receive-side link layer for the board-to-board GPIO link. It samples the forwarded serial clock, a header lane and four data lanes. It finds frames by a sync pattern, deserializes control frames (ACK/READY/LOST) and DATA frames, and checks per-lane parity. It also filters duplicate DATA by sequence bit and requests ACKs from the local sender. It sits between the GPIO pins and the game/network FSMs, in the single 50 MHz clk domain.

Parameters:
PAYLOAD_BEATS, 16, data-phase beats per DATA frame; payload width = 4*PAYLOAD_BEATS
SYNC_PATTERN, 8'h7E, header-lane sync word, MSB first
TIMEOUT_CYCLES, 5000, clk cycles without an sclk rising edge before a mid-frame abort
CNT_W, 4, width of the statistics counters

Ports:
clk  in  1  system clock (50 MHz); the only clock
rst  in  1  asynchronous, active-high reset
sclk_in  in  1  forwarded serial clock (~100 kHz), asynchronous
serial_in_h  in  1  header lane
serial_in_d  in  4  data lanes; bit i = lane i
payload  out  4*PAYLOAD_BEATS  last accepted DATA payload; held until the next accept
payload_valid  out  1  one-cycle pulse: new non-duplicate DATA accepted
payload_seq  out  1  seq bit of the last accepted DATA
ack_received  out  1  one-cycle pulse: ACK frame received
ack_seqNum  out  1  seq bit carried by the last ACK
ready_received  out  1  one-cycle pulse: READY frame received
lost_received  out  1  one-cycle pulse: LOST frame received
send_ack  out  1  one-cycle pulse: local sender must ACK
send_ack_seq  out  1  seq to ACK; valid with send_ack
packets_received_cnt  out  CNT_W  good DATA frames, duplicates included; wraps
errors_cnt  out  CNT_W  parity errors plus timeouts; wraps
busy  out  1  high in any state except HUNT

Behaviour:
- Reset (async, active-high): state=HUNT; all outputs 0; payload=0; last_seq=1, so the first DATA with seq=0 is accepted; synchronizers cleared.
- Input conditioning: sclk_in, serial_in_h and serial_in_d each pass through an identical 2-FF synchronizer. A rising edge is defined as s2 & ~s3. Lanes are sampled in the clk cycle the edge is detected.
- Frame format:
  - Header lane: 8 sync bits, then TYPE[1:0] (00 DATA, 01 ACK, 10 READY, 11 LOST), then SEQ. All fields MSB first.
  - DATA only: PAYLOAD_BEATS data beats. Beat k places lane i at payload[4k+i]; beat 0 = LSBs.
  - DATA only: one parity beat. Each lane carries even parity over its PAYLOAD_BEATS bits.
- States:
  - HUNT: on each edge, shift serial_in_h into an 8-bit window. When window==SYNC_PATTERN, go to HDR.
  - HDR: collect 3 bits. DATA goes to PAYLOAD; any other type goes to EMIT.
  - PAYLOAD: collect PAYLOAD_BEATS beats into a shadow register, then go to PARITY.
  - PARITY: one beat. Pass goes to EMIT. Fail: errors_cnt++, no pulses, return to HUNT.
  - EMIT: one cycle, then HUNT with the window cleared.
- EMIT outputs, registered; pulses are high exactly one cycle, the cycle after the final-bit edge:
  - ACK: ack_received=1; ack_seqNum=SEQ.
  - READY: ready_received=1. LOST: lost_received=1.
  - DATA, SEQ!=last_seq: copy shadow to payload; payload_valid=1; payload_seq=SEQ; last_seq=SEQ; packets_received_cnt++; send_ack=1 with send_ack_seq=SEQ.
  - DATA, SEQ==last_seq (duplicate): payload unchanged; payload_valid=0; packets_received_cnt++; send_ack=1 with send_ack_seq=SEQ. This re-ACK covers a lost ACK.
- Timeout:
  - In HDR, PAYLOAD or PARITY, a timer counts clk cycles and clears on every edge.
  - At TIMEOUT_CYCLES the block aborts to HUNT and increments errors_cnt.
  - If an edge and expiry fall in the same cycle, the edge wins.
- Sync-pattern bits inside a payload are ignored; matching happens only in HUNT.
- Reset mid-frame: immediate return to HUNT and all reset values. The partial shadow is discarded.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- NetworkPkg: pkt_type_t enum (PKT_DATA, PKT_ACK, PKT_READY, PKT_LOST), SYNC_PATTERN, PAYLOAD_BEATS, TIMEOUT_CYCLES.
- Local FSM state enum stays inside the module.
- One sub-module: gpio_synchronizer (2-FF synchronizer plus rising-edge detect, width-parameterized). It is instantiated for the sclk and lane group so latencies stay aligned.

Test Plan:
- Reset, then DATA SEQ=0, payload 64'h0123_4567_89AB_CDEF with correct parity -> payload_valid 1 cycle after the last edge, payload=0x0123456789ABCDEF, send_ack=1/send_ack_seq=0, packets_received_cnt=1.
- Same frame resent with SEQ=0 -> payload_valid stays 0, send_ack=1 with seq 0, packets_received_cnt=2, payload unchanged.
- ACK frame SEQ=1, then READY, then LOST -> one pulse each; ack_seqNum=1; payload_valid never asserts.
- DATA with lane 2 parity bit flipped -> no pulses, errors_cnt=1, busy=0 after the parity edge.
- sclk stops after 5 payload beats -> after 5000 clk cycles state is HUNT, errors_cnt+1; a following good frame is accepted.
- Payload containing 0x7E on the header-lane timing, plus a leading garbage bit stream, plus rst asserted mid-PAYLOAD -> no false sync; after reset all outputs 0 and a fresh SEQ=0 frame is accepted.
